// File: rtl/water_level_pkg.sv
// Shared types and defaults for the water level sensor filter.
// decode_level maps a filtered (low, high) probe pair onto a level state.
package water_level_pkg;

  localparam int unsigned DefaultDebounceCycles  = 4;
  localparam int unsigned DefaultFaultHoldCycles = 8;

  typedef enum logic [1:0] {
    Empty,
    Normal,
    Full,
    Fault
  } level_state_e;

  // Water above the high mark but below the low mark is physically impossible.
  function automatic level_state_e decode_level(input logic low, input logic high);
    level_state_e st;
    if (!low && high) begin
      st = Fault;
    end else if (!low) begin
      st = Empty;
    end else if (!high) begin
      st = Normal;
    end else begin
      st = Full;
    end
    return st;
  endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter
// for one asynchronous level probe.
module sensor_debouncer
  import water_level_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [7:0] cnt_q, cnt_d;

  // Accept the new value on the edge where the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/water_level_sensor_filter.sv
// Debounces the low/high water probes and tracks the tank level, holding a
// fault indication until the probes have agreed for FAULT_HOLD_CYCLES cycles.
module water_level_sensor_filter
  import water_level_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DefaultDebounceCycles,
  parameter int unsigned FAULT_HOLD_CYCLES = DefaultFaultHoldCycles
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       low_sensor_raw,
  input  logic       high_sensor_raw,
  output logic       low_water_level,
  output logic       high_water_level,
  output logic       water_sensors_conflicting,
  output logic [7:0] fault_count
);

  localparam logic [7:0] HoldMax = 8'(FAULT_HOLD_CYCLES);

  logic         low_filt, high_filt;
  level_state_e state_q, state_d, pair_state;
  logic [7:0]   hold_q, hold_d;
  logic [7:0]   fault_count_q, fault_count_d;

  sensor_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_low_debouncer (
    .clk_i (clock),
    .rst_i (reset),
    .raw_i (low_sensor_raw),
    .filt_o(low_filt)
  );

  sensor_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_high_debouncer (
    .clk_i (clock),
    .rst_i (reset),
    .raw_i (high_sensor_raw),
    .filt_o(high_filt)
  );

  assign pair_state = decode_level(low_filt, high_filt);

  always_comb begin
    state_d       = state_q;
    hold_d        = '0;
    fault_count_d = fault_count_q;
    if (state_q != Fault) begin
      state_d = pair_state;
      if (pair_state == Fault && fault_count_q != 8'hff) begin
        fault_count_d = fault_count_q + 8'd1;
      end
    end else if (pair_state != Fault) begin
      // Hold counter saturates; leave only after a full quiet window.
      hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 8'd1;
      if (hold_q == HoldMax) begin
        state_d = pair_state;
      end
    end
  end

  // Reset parks in Fault so the valve stays closed until the probes settle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= Fault;
      hold_q        <= '0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      fault_count_q <= fault_count_d;
    end
  end

  always_comb begin
    low_water_level           = 1'b0;
    high_water_level          = 1'b0;
    water_sensors_conflicting = 1'b0;
    unique case (state_q)
      Empty:   ;
      Normal:  low_water_level = 1'b1;
      Full: begin
        low_water_level  = 1'b1;
        high_water_level = 1'b1;
      end
      Fault:   water_sensors_conflicting = 1'b1;
      default: water_sensors_conflicting = 1'b1;
    endcase
  end

  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_water_level_sensor_filter.sv
// Self-checking bench for water_level_sensor_filter with a window-based
// reference model of the debounce and fault-hold rules.
module tb_water_level_sensor_filter;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 8;
  localparam logic [10:0] RESET_OUT = {1'b0, 1'b0, 1'b1, 8'd0};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       low_sensor_raw = 1'b0;
  logic       high_sensor_raw = 1'b0;
  logic       low_water_level, high_water_level, water_sensors_conflicting;
  logic [7:0] fault_count;
  logic [10:0] dut_out;

  int nvec = 0;
  int nerr = 0;

  water_level_sensor_filter #(
    .DEBOUNCE_CYCLES  (DB),
    .FAULT_HOLD_CYCLES(HOLD)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .low_sensor_raw           (low_sensor_raw),
    .high_sensor_raw          (high_sensor_raw),
    .low_water_level          (low_water_level),
    .high_water_level         (high_water_level),
    .water_sensors_conflicting(water_sensors_conflicting),
    .fault_count              (fault_count)
  );

  assign dut_out = {low_water_level, high_water_level, water_sensors_conflicting, fault_count};

  always #5 clock = ~clock;

  // Reference model. Level codes: 0 empty, 1 normal, 2 full, 3 fault.
  bit m_s1l, m_s2l, m_s1h, m_s2h, m_fl, m_fh;
  bit hist_l[$];
  bit hist_h[$];
  int m_st, m_fc, e, last_conf;

  function automatic int m_decode(bit l, bit h);
    if (!l && h) return 3;
    if (!l) return 0;
    if (!h) return 1;
    return 2;
  endfunction

  // Filter flips once the last DB synchronized samples all disagree with it.
  function automatic bit all_differ(bit q[$], bit f);
    if (q.size() != DB) return 1'b0;
    foreach (q[i]) if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [10:0] m_out();
    logic [10:0] v;
    v[10]  = (m_st == 1 || m_st == 2);
    v[9]   = (m_st == 2);
    v[8]   = (m_st == 3);
    v[7:0] = 8'(m_fc);
    return v;
  endfunction

  function automatic void model_reset();
    m_s1l = 0; m_s2l = 0; m_s1h = 0; m_s2h = 0; m_fl = 0; m_fh = 0;
    hist_l.delete();
    hist_h.delete();
    m_st = 3;
    m_fc = 0;
    last_conf = e;
  endfunction

  function automatic void model_step();
    int pair;
    if (reset) begin
      model_reset();
      e++;
      return;
    end
    pair = m_decode(m_fl, m_fh);
    if (m_st != 3) begin
      if (pair == 3) begin
        if (m_fc < 255) m_fc++;
        last_conf = e;
      end
      m_st = pair;
    end else if (pair == 3) begin
      last_conf = e;
    end else if (e - last_conf > int'(HOLD)) begin
      m_st = pair;
    end
    hist_l.push_back(m_s2l);
    hist_h.push_back(m_s2h);
    if (hist_l.size() > DB) void'(hist_l.pop_front());
    if (hist_h.size() > DB) void'(hist_h.pop_front());
    if (all_differ(hist_l, m_fl)) m_fl = !m_fl;
    if (all_differ(hist_h, m_fh)) m_fh = !m_fh;
    m_s2l = m_s1l; m_s1l = low_sensor_raw;
    m_s2h = m_s1h; m_s1h = high_sensor_raw;
    e++;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    low_sensor_raw = 1'b0;
    high_sensor_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (dut_out !== RESET_OUT) begin
        nerr++;
        $display("FAIL reset_hold: got %h want %h", dut_out, RESET_OUT);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      nvec++;
      if (water_sensors_conflicting !== (i < 9) || dut_out !== m_out()) begin
        nerr++;
        $display("FAIL reset_release edge %0d: got %h want %h", i, dut_out, m_out());
      end
    end
  endtask

  task automatic test_fill_latency();
    low_sensor_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      nvec++;
      if (low_water_level !== (i == 7) || high_water_level !== 1'b0 || dut_out !== m_out()) begin
        nerr++;
        $display("FAIL fill_latency edge %0d: got %h want low=%0d model %h",
                 i, dut_out, (i == 7), m_out());
      end
    end
  endtask

  task automatic test_pulses();
    bit seen_full = 0;
    high_sensor_raw = 1'b1;
    repeat (3) tick();
    high_sensor_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      nvec++;
      if (dut_out !== {1'b1, 1'b0, 1'b0, 8'd0} || dut_out !== m_out()) begin
        nerr++;
        $display("FAIL short_pulse: got %h want %h", dut_out, m_out());
      end
    end
    high_sensor_raw = 1'b1;
    repeat (4) tick();
    high_sensor_raw = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (high_water_level === 1'b1) seen_full = 1;
      nvec++;
      if (dut_out !== m_out()) begin
        nerr++;
        $display("FAIL long_pulse: got %h want %h", dut_out, m_out());
      end
    end
    nvec++;
    if (seen_full !== 1'b1) begin
      nerr++;
      $display("FAIL long_pulse_full: got seen_full=%0d want 1", seen_full);
    end
  endtask

  task automatic test_fault();
    int edges = 0;
    low_sensor_raw = 1'b0;
    high_sensor_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      nvec++;
      if (dut_out !== m_out()) begin
        nerr++;
        $display("FAIL fault_entry: got %h want %h", dut_out, m_out());
      end
    end
    nvec++;
    if (water_sensors_conflicting !== 1'b1 || fault_count !== 8'd1) begin
      nerr++;
      $display("FAIL fault_count_one: got conf=%0b count=%0d want 1/1",
               water_sensors_conflicting, fault_count);
    end
    low_sensor_raw = 1'b1;
    while (edges < 40 && high_water_level !== 1'b1) begin
      tick();
      edges++;
      nvec++;
      if (dut_out !== m_out()) begin
        nerr++;
        $display("FAIL fault_hold: got %h want %h", dut_out, m_out());
      end
    end
    nvec++;
    if (edges != int'(DB + 2 + HOLD + 1)) begin
      nerr++;
      $display("FAIL fault_exit_edges: got %0d want %0d", edges, DB + 2 + HOLD + 1);
    end
  endtask

  task automatic test_reset_mid();
    low_sensor_raw = 1'b0;
    repeat (4) tick();
    #3;
    reset = 1'b1;
    #1;
    nvec++;
    if (dut_out !== RESET_OUT) begin
      nerr++;
      $display("FAIL async_reset: got %h want %h", dut_out, RESET_OUT);
    end
    high_sensor_raw = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nvec++;
      if (low_water_level !== 1'b0 || dut_out !== m_out()) begin
        nerr++;
        $display("FAIL stale_after_reset: got %h want %h", dut_out, m_out());
      end
    end
  endtask

  task automatic test_random();
    int run;
    for (int i = 0; i < 150; i++) begin
      low_sensor_raw  = 1'($urandom_range(0, 1));
      high_sensor_raw = 1'($urandom_range(0, 1));
      run = $urandom_range(1, 12);
      for (int k = 0; k < run; k++) begin
        if ($urandom_range(0, 7) == 0) low_sensor_raw = ~low_sensor_raw;
        tick();
        nvec++;
        if (dut_out !== m_out()) begin
          nerr++;
          $display("FAIL random: got %h want %h", dut_out, m_out());
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] prev = 8'd0;
    bit stuck = 0;
    reset = 1'b1;
    low_sensor_raw = 1'b0;
    high_sensor_raw = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int n = 0; n < 256 && !stuck; n++) begin
      for (int phase = 0; phase < 2; phase++) begin
        high_sensor_raw = (phase == 0);
        for (int k = 0; k < 40 && water_sensors_conflicting !== (phase == 0); k++) begin
          tick();
          nvec++;
          if (dut_out !== m_out() || fault_count < prev) begin
            nerr++;
            $display("FAIL saturation_step: got %h want %h prev count %0d",
                     dut_out, m_out(), prev);
          end
          prev = fault_count;
        end
        nvec++;
        if (water_sensors_conflicting !== (phase == 0)) begin
          nerr++;
          stuck = 1;
          $display("FAIL saturation_timeout: got conf=%0b want %0b",
                   water_sensors_conflicting, (phase == 0));
        end
      end
    end
    nvec++;
    if (fault_count !== 8'd255) begin
      nerr++;
      $display("FAIL saturation_final: got %0d want 255", fault_count);
    end
  endtask

  initial begin
    e = 0;
    model_reset();
    test_reset();
    test_fill_latency();
    test_pulses();
    test_fault();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
